// File: rtl/lsq_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// lsq_mem_port_arbiter
//
// Shares the single data-memory port between the load-issue side and the
// store-drain side of the load/store queue. While idle it picks at most one
// requester, latches that request and presents it to memory with a
// valid/ready handshake. Stores are posted (no response). A load is tracked
// until its data returns, or until a timeout, and a one-cycle tagged response
// goes back to the load side. Only one memory transaction is outstanding at
// any time.
//
// Arbitration when both sides are valid:
//   1. store wins on a same-word address match (store-before-load ordering),
//   2. store wins once STARVE_LIMIT consecutive loads have been granted while
//      it waited,
//   3. otherwise load wins.
//
// Ports:
//   clk            clock, rising edge
//   reset          asynchronous active-low reset
//   ld_valid/ld_ready/ld_addr/ld_tag          load request side
//   st_valid/st_ready/st_addr/st_data         store request side
//   mem_req_valid/mem_req_ready/mem_we/mem_addr/mem_wdata   memory request
//   mem_rvalid/mem_rdata                      memory load data return
//   ld_resp_valid/ld_resp_tag/ld_resp_data/ld_resp_err      load completion
//   busy           high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module lsq_mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int TAG_W        = 4,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [TAG_W-1:0]  ld_tag,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ld_resp_valid,
  output logic [TAG_W-1:0]  ld_resp_tag,
  output logic [DATA_W-1:0] ld_resp_data,
  output logic              ld_resp_err,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_LD_WAIT = 2'd2
  } state_e;

  // Last counter value before a load is declared timed out: counting from 0
  // on LD_WAIT entry, the error response appears TIMEOUT cycles after entry.
  localparam logic [3:0] STARVE_LIM_C = 4'(STARVE_LIMIT);
  localparam logic [7:0] TO_LAST_C    = 8'(TIMEOUT - 1);

  state_e              state_r;
  state_e              state_nxt_s;
  logic [3:0]          starve_cnt_r;
  logic [7:0]          to_cnt_r;

  logic                req_we_r;
  logic [ADDR_W-1:0]   req_addr_r;
  logic [DATA_W-1:0]   req_wdata_r;
  logic [TAG_W-1:0]    req_tag_r;

  logic                req_valid_r;
  logic                busy_r;
  logic                rsp_valid_r;
  logic [TAG_W-1:0]    rsp_tag_r;
  logic [DATA_W-1:0]   rsp_data_r;
  logic                rsp_err_r;

  logic                same_word_s;
  logic                starve_hit_s;
  logic                grant_ld_s;
  logic                grant_st_s;
  logic                mem_hs_s;
  logic                rsp_ok_s;
  logic                rsp_to_s;

  // Arbitration between load and store requesters while idle
  always_comb begin
    same_word_s  = 1'b0;
    starve_hit_s = 1'b0;
    grant_ld_s   = 1'b0;
    grant_st_s   = 1'b0;
    same_word_s  = (st_addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2]);
    starve_hit_s = (starve_cnt_r == STARVE_LIM_C);
    if (state_r == ST_IDLE) begin
      if (ld_valid && st_valid) begin
        if (same_word_s || starve_hit_s) begin
          grant_st_s = 1'b1;
        end else begin
          grant_ld_s = 1'b1;
        end
      end else if (ld_valid) begin
        grant_ld_s = 1'b1;
      end else if (st_valid) begin
        grant_st_s = 1'b1;
      end else begin
        grant_ld_s = 1'b0;
        grant_st_s = 1'b0;
      end
    end else begin
      grant_ld_s = 1'b0;
      grant_st_s = 1'b0;
    end
  end

  // The state register already holds IDLE during reset, so the readies are
  // also gated by reset itself to keep every output at 0 while it is asserted.
  assign ld_ready = grant_ld_s & reset;
  assign st_ready = grant_st_s & reset;

  // Next-state logic and per-cycle event decode
  always_comb begin
    state_nxt_s = state_r;
    mem_hs_s    = 1'b0;
    rsp_ok_s    = 1'b0;
    rsp_to_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (grant_ld_s || grant_st_s) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mem_req_ready) begin
          mem_hs_s    = 1'b1;
          state_nxt_s = req_we_r ? ST_IDLE : ST_LD_WAIT;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_LD_WAIT: begin
        if (mem_rvalid) begin
          rsp_ok_s    = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (to_cnt_r == TO_LAST_C) begin
          rsp_to_s    = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_LD_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Store starvation counter: consecutive load grants while a store waits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_r <= 4'd0;
    end else if (state_r == ST_IDLE) begin
      if (grant_st_s || !st_valid) begin
        starve_cnt_r <= 4'd0;
      end else if (grant_ld_s && (starve_cnt_r != STARVE_LIM_C)) begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Load timeout counter: runs only while staying in LD_WAIT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_r <= 8'd0;
    end else if ((state_r == ST_LD_WAIT) && (state_nxt_s == ST_LD_WAIT)) begin
      to_cnt_r <= to_cnt_r + 8'd1;
    end else begin
      to_cnt_r <= 8'd0;
    end
  end

  // Request register: captures the winning request at grant time
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_we_r    <= 1'b0;
      req_addr_r  <= {ADDR_W{1'b0}};
      req_wdata_r <= {DATA_W{1'b0}};
      req_tag_r   <= {TAG_W{1'b0}};
    end else if (grant_st_s) begin
      req_we_r    <= 1'b1;
      req_addr_r  <= st_addr;
      req_wdata_r <= st_data;
      req_tag_r   <= {TAG_W{1'b0}};
    end else if (grant_ld_s) begin
      req_we_r    <= 1'b0;
      req_addr_r  <= ld_addr;
      req_wdata_r <= {DATA_W{1'b0}};
      req_tag_r   <= ld_tag;
    end else begin
      req_we_r    <= req_we_r;
      req_addr_r  <= req_addr_r;
      req_wdata_r <= req_wdata_r;
      req_tag_r   <= req_tag_r;
    end
  end

  // Registered status flags, derived from the next state so they line up
  // with the state they describe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      req_valid_r <= (state_nxt_s == ST_ISSUE);
      busy_r      <= (state_nxt_s != ST_IDLE);
    end
  end

  // Load response register: one-cycle pulse, all fields 0 otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_r <= 1'b0;
      rsp_tag_r   <= {TAG_W{1'b0}};
      rsp_data_r  <= {DATA_W{1'b0}};
      rsp_err_r   <= 1'b0;
    end else if (rsp_ok_s) begin
      rsp_valid_r <= 1'b1;
      rsp_tag_r   <= req_tag_r;
      rsp_data_r  <= mem_rdata;
      rsp_err_r   <= 1'b0;
    end else if (rsp_to_s) begin
      rsp_valid_r <= 1'b1;
      rsp_tag_r   <= req_tag_r;
      rsp_data_r  <= {DATA_W{1'b0}};
      rsp_err_r   <= 1'b1;
    end else begin
      rsp_valid_r <= 1'b0;
      rsp_tag_r   <= {TAG_W{1'b0}};
      rsp_data_r  <= {DATA_W{1'b0}};
      rsp_err_r   <= 1'b0;
    end
  end

  assign mem_req_valid = req_valid_r;
  assign mem_we        = req_we_r;
  assign mem_addr      = req_addr_r;
  assign mem_wdata     = req_wdata_r;
  assign ld_resp_valid = rsp_valid_r;
  assign ld_resp_tag   = rsp_tag_r;
  assign ld_resp_data  = rsp_data_r;
  assign ld_resp_err   = rsp_err_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_lsq_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lsq_mem_port_arbiter
//
// Directed scenarios drive the arbiter; every expected memory request and
// every expected load response is pushed to a queue when the stimulus is
// applied, and a negedge monitor pops and compares them as the DUT produces
// them. Scenario-specific timing is checked inline.
// -----------------------------------------------------------------------------
module tb_lsq_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [AW-1:0] ld_addr = 32'd0;
  logic [TW-1:0] ld_tag = 4'd0;
  logic          st_valid = 1'b0;
  logic          st_ready;
  logic [AW-1:0] st_addr = 32'd0;
  logic [DW-1:0] st_data = 32'd0;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = 32'd0;
  logic          ld_resp_valid;
  logic [TW-1:0] ld_resp_tag;
  logic [DW-1:0] ld_resp_data;
  logic          ld_resp_err;
  logic          busy;

  always #5 clk = ~clk;

  lsq_mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TAG_W(TW), .STARVE_LIMIT(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_tag(ld_tag),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ld_resp_valid(ld_resp_valid), .ld_resp_tag(ld_resp_tag),
    .ld_resp_data(ld_resp_data), .ld_resp_err(ld_resp_err),
    .busy(busy)
  );

  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } req_t;
  typedef struct { logic [TW-1:0] tag; logic [DW-1:0] data; logic err; } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  int   vec_cnt = 0;
  int   miscmp_cnt = 0;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wdata;
    req_q.push_back(r);
  endtask

  task automatic push_rsp(input logic [TW-1:0] tag, input logic [DW-1:0] data, input logic err);
    rsp_t r;
    r.tag = tag; r.data = data; r.err = err;
    rsp_q.push_back(r);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: memory handshakes and load responses, sampled mid-cycle
  always @(negedge clk) begin
    req_t er;
    rsp_t ep;
    if (reset === 1'b1) begin
      check_vec("rdy_mutex", 64'(ld_ready & st_ready), 64'd0);
      if (mem_req_valid && mem_req_ready) begin
        check_vec("req_expected", 64'(req_q.size() != 0), 64'd1);
        if (req_q.size() != 0) begin
          er = req_q.pop_front();
          check_vec("req_we", 64'(mem_we), 64'(er.we));
          check_vec("req_addr", 64'(mem_addr), 64'(er.addr));
          check_vec("req_wdata", 64'(mem_wdata), 64'(er.wdata));
        end
      end
      if (ld_resp_valid) begin
        check_vec("rsp_expected", 64'(rsp_q.size() != 0), 64'd1);
        if (rsp_q.size() != 0) begin
          ep = rsp_q.pop_front();
          check_vec("rsp_tag", 64'(ld_resp_tag), 64'(ep.tag));
          check_vec("rsp_data", 64'(ld_resp_data), 64'(ep.data));
          check_vec("rsp_err", 64'(ld_resp_err), 64'(ep.err));
        end
      end else begin
        check_vec("rsp_idle_zero", 64'({ld_resp_tag, ld_resp_data, ld_resp_err}), 64'd0);
      end
    end
  end

  initial begin
    int k;
    logic g_ld;
    logic g_st;

    // ---------------- reset state ----------------
    reset = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'h0000_0040;
    st_valid = 1'b1; st_addr = 32'h0000_0080; st_data = 32'h0000_0011;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_vec("rst_ld_ready", 64'(ld_ready), 64'd0);
    check_vec("rst_st_ready", 64'(st_ready), 64'd0);
    check_vec("rst_outputs", 64'({mem_req_valid, mem_we, busy, ld_resp_valid, ld_resp_err}), 64'd0);
    check_vec("rst_mem_addr", 64'(mem_addr), 64'd0);
    next_cyc();
    reset = 1'b1;
    ld_valid = 1'b0; st_valid = 1'b0;

    // ---------------- lone load ----------------
    next_cyc();                                   // N
    ld_valid = 1'b1; ld_addr = 32'h0000_0100; ld_tag = 4'd3; mem_req_ready = 1'b1;
    push_req(1'b0, 32'h0000_0100, 32'd0);
    @(negedge clk);
    check_vec("t1_ld_ready", 64'(ld_ready), 64'd1);
    check_vec("t1_st_ready", 64'(st_ready), 64'd0);
    check_vec("t1_busy_idle", 64'(busy), 64'd0);
    next_cyc();                                   // N+1 issue
    ld_valid = 1'b0;
    @(negedge clk);
    check_vec("t1_issue_valid", 64'(mem_req_valid), 64'd1);
    check_vec("t1_issue_we", 64'(mem_we), 64'd0);
    check_vec("t1_busy", 64'(busy), 64'd1);
    next_cyc();                                   // N+2 LD_WAIT
    @(negedge clk);
    check_vec("t1_wait_novalid", 64'(mem_req_valid), 64'd0);
    next_cyc();                                   // N+3 data return
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    push_rsp(4'd3, 32'hDEAD_BEEF, 1'b0);
    next_cyc();                                   // N+4 response
    mem_rvalid = 1'b0; mem_rdata = 32'd0;
    @(negedge clk);
    check_vec("t1_rsp_valid", 64'(ld_resp_valid), 64'd1);
    check_vec("t1_busy_after", 64'(busy), 64'd0);
    next_cyc();
    @(negedge clk);
    check_vec("t1_rsp_pulse", 64'(ld_resp_valid), 64'd0);

    // ---------------- same-word hazard ----------------
    next_cyc();                                   // A
    ld_valid = 1'b1; ld_addr = 32'h0000_0104; ld_tag = 4'd5;
    st_valid = 1'b1; st_addr = 32'h0000_0107; st_data = 32'h0000_0055;
    push_req(1'b1, 32'h0000_0107, 32'h0000_0055);
    push_req(1'b0, 32'h0000_0104, 32'd0);
    @(negedge clk);
    check_vec("t2_st_first", 64'(st_ready), 64'd1);
    check_vec("t2_ld_held", 64'(ld_ready), 64'd0);
    next_cyc();                                   // A+1 store issue
    st_valid = 1'b0;
    @(negedge clk);
    check_vec("t2_issue_addr", 64'(mem_addr), 64'h107);
    check_vec("t2_issue_ld_ready", 64'(ld_ready), 64'd0);
    next_cyc();                                   // A+2 load grant
    @(negedge clk);
    check_vec("t2_ld_next", 64'(ld_ready), 64'd1);
    next_cyc();                                   // A+3 load issue
    ld_valid = 1'b0;
    next_cyc();                                   // A+4 LD_WAIT
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    push_rsp(4'd5, 32'h0BAD_F00D, 1'b0);
    next_cyc();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check_vec("t2_rsp_valid", 64'(ld_resp_valid), 64'd1);

    // ---------------- starvation bound ----------------
    for (int i = 0; i < 4; i++) begin
      push_req(1'b0, 32'h0000_0200 + 32'(16 * i), 32'd0);
      push_rsp(4'(i), 32'hC0DE_0000 + 32'(i), 1'b0);
    end
    push_req(1'b1, 32'h0000_0800, 32'h0000_0077);
    for (int i = 4; i < 6; i++) begin
      push_req(1'b0, 32'h0000_0200 + 32'(16 * i), 32'd0);
      push_rsp(4'(i), 32'hC0DE_0000 + 32'(i), 1'b0);
    end
    next_cyc();
    k = 0;
    ld_valid = 1'b1; ld_addr = 32'h0000_0200; ld_tag = 4'd0;
    st_valid = 1'b1; st_addr = 32'h0000_0800; st_data = 32'h0000_0077;
    mem_rvalid = 1'b1;
    for (int c = 0; c < 80 && k < 6; c++) begin
      @(negedge clk);
      g_ld = ld_ready;
      g_st = st_ready;
      next_cyc();
      if (g_ld) begin
        mem_rdata = 32'hC0DE_0000 + 32'(k);
        k++;
        ld_addr = 32'h0000_0200 + 32'(16 * k);
        ld_tag = 4'(k);
      end
      if (g_st) st_valid = 1'b0;
    end
    ld_valid = 1'b0;
    repeat (3) next_cyc();
    mem_rvalid = 1'b0;
    check_vec("t3_load_grants", 64'(k), 64'd6);

    // ---------------- backpressure ----------------
    next_cyc();                                   // S
    st_valid = 1'b1; st_addr = 32'h0000_0300; st_data = 32'h1234_5678;
    mem_req_ready = 1'b0;
    push_req(1'b1, 32'h0000_0300, 32'h1234_5678);
    @(negedge clk);
    check_vec("t4_st_grant", 64'(st_ready), 64'd1);
    for (int i = 1; i <= 5; i++) begin
      next_cyc();
      if (i == 1) begin
        ld_valid = 1'b1; ld_addr = 32'h0000_0400; ld_tag = 4'd7;
      end
      @(negedge clk);
      check_vec("t4_stall_valid", 64'(mem_req_valid), 64'd1);
      check_vec("t4_stall_req", 64'({mem_we, mem_addr, mem_wdata}), {31'd0, 1'b1, 32'h0000_0300, 32'h1234_5678} >> 0);
      check_vec("t4_stall_ready", 64'({ld_ready, st_ready}), 64'd0);
    end
    next_cyc();                                   // S+6 handshake
    mem_req_ready = 1'b1; ld_valid = 1'b0; st_valid = 1'b0;
    @(negedge clk);
    check_vec("t4_hs_valid", 64'(mem_req_valid), 64'd1);
    next_cyc();
    @(negedge clk);
    check_vec("t4_done_valid", 64'(mem_req_valid), 64'd0);
    check_vec("t4_done_busy", 64'(busy), 64'd0);

    // ---------------- timeout ----------------
    next_cyc();                                   // T
    ld_valid = 1'b1; ld_addr = 32'h0000_0500; ld_tag = 4'd9;
    push_req(1'b0, 32'h0000_0500, 32'd0);
    push_rsp(4'd9, 32'd0, 1'b1);
    next_cyc();                                   // T+1 issue
    ld_valid = 1'b0;
    next_cyc();                                   // T+2 LD_WAIT entry
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_vec("t5_no_early_rsp", 64'(ld_resp_valid), 64'd0);
      next_cyc();
    end
    @(negedge clk);                               // T+10
    check_vec("t5_to_valid", 64'(ld_resp_valid), 64'd1);
    check_vec("t5_to_err", 64'(ld_resp_err), 64'd1);
    check_vec("t5_to_idle", 64'(busy), 64'd0);

    // ---------------- reset during LD_WAIT ----------------
    next_cyc();                                   // R
    ld_valid = 1'b1; ld_addr = 32'h0000_0600; ld_tag = 4'd2;
    push_req(1'b0, 32'h0000_0600, 32'd0);
    next_cyc();                                   // R+1 issue
    ld_valid = 1'b0;
    next_cyc();                                   // R+2 LD_WAIT
    @(negedge clk);
    check_vec("t6_busy_wait", 64'(busy), 64'd1);
    #2;
    reset = 1'b0;
    ld_valid = 1'b1; st_valid = 1'b1; st_addr = 32'h0000_0700;
    #1;
    check_vec("t6_rst_ready", 64'({ld_ready, st_ready}), 64'd0);
    check_vec("t6_rst_ctrl", 64'({mem_req_valid, mem_we, busy, ld_resp_valid, ld_resp_err}), 64'd0);
    check_vec("t6_rst_addr", 64'(mem_addr), 64'd0);
    check_vec("t6_rst_resp", 64'({ld_resp_tag, ld_resp_data}), 64'd0);
    @(posedge clk);
    #3;
    ld_valid = 1'b0; st_valid = 1'b0;
    reset = 1'b1;
    next_cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_vec("t6_no_late_rsp", 64'(ld_resp_valid), 64'd0);
      check_vec("t6_idle", 64'(busy), 64'd0);
      next_cyc();
    end
    mem_rvalid = 1'b0;

    next_cyc();
    check_vec("req_q_drained", 64'(req_q.size()), 64'd0);
    check_vec("rsp_q_drained", 64'(rsp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule

// File: doc/lsq_mem_port_arbiter.md
# lsq_mem_port_arbiter

Sequential arbiter sharing the single data-memory port between the load-issue side and the store-drain side of the load/store queue. It sits between the queue and the memory access controller. Each cycle it selects at most one requester, registers the request, presents it to memory with a valid/ready handshake, tracks the one outstanding load until its data returns, and returns that data tagged to the load side. It also enforces same-address store-before-load ordering and bounds store starvation.

## Interface

Parameters:
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- TAG_W, 4: load tag width.
- STARVE_LIMIT, 4: consecutive load grants allowed while a store waits (1..15).
- TIMEOUT, 64: cycles allowed in LD_WAIT before an error is declared (2..255).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- ld_valid  in  1  load request pending.
- ld_ready  out  1  load request accepted this cycle.
- ld_addr  in  ADDR_W  load effective address.
- ld_tag  in  TAG_W  load identifier.
- st_valid  in  1  store request pending.
- st_ready  out  1  store request accepted this cycle.
- st_addr  in  ADDR_W  store effective address.
- st_data  in  DATA_W  store data.
- mem_req_valid  out  1  request presented to memory.
- mem_req_ready  in  1  memory accepts the request.
- mem_we  out  1  1 = store, 0 = load.
- mem_addr  out  ADDR_W  request address.
- mem_wdata  out  DATA_W  store data; 0 for loads.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  DATA_W  load data.
- ld_resp_valid  out  1  one-cycle load completion pulse.
- ld_resp_tag  out  TAG_W  tag of the completed load.
- ld_resp_data  out  DATA_W  returned data; 0 on timeout.
- ld_resp_err  out  1  qualifies ld_resp_valid; 1 = timeout.
- busy  out  1  state is not IDLE.

## Operation

- FSM states: IDLE, ISSUE, LD_WAIT.
- IDLE: arbitrate. The winner sees its ready = 1 combinationally. The request is latched into the request register and the FSM moves to ISSUE. With no valid requester, the FSM stays in IDLE.
- Arbitration priority, evaluated in IDLE when both requesters are valid:
  1. Store wins if st_addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2] (same-word hazard).
  2. Otherwise, store wins if starve_cnt == STARVE_LIMIT.
  3. Otherwise, load wins.
- With only one requester valid, that requester wins.
- starve_cnt (4-bit counter):
  - Cleared on any store grant.
  - Cleared when st_valid = 0 in IDLE.
  - Incremented on a load grant while st_valid = 1.
  - Saturates at STARVE_LIMIT.
- ISSUE: mem_req_valid = 1 with the latched mem_we/mem_addr/mem_wdata, held stable until mem_req_ready.
  - On handshake, a store goes to IDLE (posted; no response).
  - On handshake, a load goes to LD_WAIT with the timeout counter cleared.
- LD_WAIT:
  - mem_rvalid = 1: capture mem_rdata and pulse ld_resp_valid with err = 0 the next cycle; go to IDLE.
  - Counter reaches TIMEOUT - 1 without mem_rvalid: pulse ld_resp_valid with err = 1 and data = 0; go to IDLE.
  - mem_rvalid outside LD_WAIT is ignored.
- Exactly one memory transaction is outstanding at a time. ld_ready and st_ready are never both 1 and are 0 outside IDLE.
- Reset (asynchronous assert, mid-operation included):
  - State = IDLE; all counters = 0.
  - All outputs = 0; the in-flight load is dropped with no response.
- Release: synchronous to clk, with normal operation from the first edge after release.

## Timing

- Store: accepted in cycle N; mem_req_valid is seen from N+1; returns to IDLE one cycle after the handshake. With mem_req_ready = 1, the next grant is possible at N+2.
- Load: accepted at N; issued at N+1 (mem_req_ready = 1); LD_WAIT from N+2. With mem_rvalid at cycle M, ld_resp_valid is high at M+1 and the FSM is in IDLE at M+1, so a new grant is possible at M+1.
- ld_resp_valid, ld_resp_tag, ld_resp_data and ld_resp_err are registered. They are valid for exactly one cycle and are 0 otherwise.
- busy is registered from state and is 0 in IDLE.

## Test plan

- Lone load: ld_addr = 0x100, tag = 3; memory ready; mem_rvalid = 1 with data 0xDEADBEEF two cycles after issue -> mem_req issued at N+1 with we = 0, then a one-cycle ld_resp_valid with tag 3, data 0xDEADBEEF, err 0.
- Same-word hazard: simultaneous load 0x104 and store 0x107 with data 0x55 -> store granted first (mem_we = 1, addr 0x107); load granted in the following IDLE.
- Starvation, STARVE_LIMIT = 4: continuous loads to distinct words plus a constant store -> exactly 4 loads are granted, then the store, then loads resume.
- Backpressure: mem_req_ready held 0 for 5 cycles in ISSUE -> mem_req_valid/addr/wdata stay stable, no ready is given to either requester, and the handshake completes on cycle 6.
- Timeout, TIMEOUT = 8: load issued, mem_rvalid never asserted -> ld_resp_valid = 1 with err = 1 and data = 0 exactly 8 cycles after entry to LD_WAIT; FSM back in IDLE.
- Reset mid-LD_WAIT: reset driven to 0 asynchronously between edges -> all outputs are 0 immediately; after release, a late mem_rvalid produces no response.
